// File: rtl/core_pkg.sv
// Shared core definitions: sequencer phase codes, the NOP encoding and the reset PC,
// used by the sequencer and the register file.
package core_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_RREAD  = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_MEM    = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Only the two low bits decide word alignment of a fetch address.
    function automatic logic pc_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Cycle and retired-instruction counters for the core sequencer; only built when
// PERF_CNT_EN is defined, so the default build carries no counter flops.
`ifdef PERF_CNT_EN
module seq_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cycle_en,
    input  logic             instret_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cycle_en)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instret_en)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/core_sequencer.sv
// Multi-cycle core sequencer: FETCH/DECODE/RREAD/EXEC/MEM/WB phases with a HALT trap.
// Define PERF_CNT_EN to build the cycle/instret counters (otherwise they read 0).
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [2:0]  state,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_result,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_illegal,
    input  logic [31:0] pc_next,
    output logic        retire,
    output logic        halted,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    logic [2:0] state_nxt;

    assign imem_req  = (state == ST_FETCH);
    assign dmem_req  = (state == ST_MEM);
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    // A misaligned target never retires; WB diverts to HALT instead.
    assign retire    = (state == ST_WB) && pc_aligned(pc_next[1:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (imem_ack) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = dec_illegal ? ST_HALT : ST_RREAD;
            ST_RREAD:  state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = (dec_is_load || dec_is_store) ? ST_MEM : ST_WB;
            ST_MEM:    if (dmem_ack) state_nxt = ST_WB;
            ST_WB:     state_nxt = pc_aligned(pc_next[1:0]) ? ST_FETCH : ST_HALT;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            load_result <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH && imem_ack)
                instr <= imem_rdata;
            if (state == ST_MEM && dmem_ack && dec_is_load)
                load_result <= dmem_rdata;
            if (retire)
                pc <= pc_next;
        end
    end

`ifdef PERF_CNT_EN
    seq_perf_cnt #(
        .CNT_W (32)
    ) u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .cycle_en    (state != ST_HALT),
        .instret_en  (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a per-cycle expectation queue.
module tb_core_sequencer;

    localparam logic [31:0] RPC = 32'h0000_1000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_RREAD = 3'd2,
                           S_EXEC = 3'd3, S_WB = 3'd4, S_MEM = 3'd5, S_HALT = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic        imem_req, imem_ack, dmem_req, dmem_ack;
    logic [31:0] imem_addr, imem_rdata, dmem_rdata, load_result, instr, pc, pc_next;
    logic        dec_is_load, dec_is_store, dec_illegal;
    logic        retire, halted;
    logic [31:0] cycle_cnt, instret_cnt;

    typedef struct {
        logic [2:0]  st;
        logic        ret;
        logic [31:0] pc;
        logic        ireq;
        logic        dreq;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cur_pc;
    logic [31:0] exp_load;
    logic [2:0]  cur_st = S_FETCH;
    logic        cur_ret = 1'b0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ins = 0;

    core_sequencer #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .load_result (load_result),
        .instr       (instr),
        .pc          (pc),
        .dec_is_load (dec_is_load),
        .dec_is_store(dec_is_store),
        .dec_illegal (dec_illegal),
        .pc_next     (pc_next),
        .retire      (retire),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic ret, input logic [31:0] p,
                        input logic ireq, input logic dreq);
        exp_t e;
        e.st = st; e.ret = ret; e.pc = p; e.ireq = ireq; e.dreq = dreq;
        sb.push_back(e);
    endtask

    // Advance one clock and compare the DUT against the oldest queued expectation.
    task automatic tick();
        exp_t e;
        if (rst_n === 1'b0) begin
            m_cyc = 0;
            m_ins = 0;
        end else begin
            if (cur_st != S_HALT) m_cyc = m_cyc + 1;
            if (cur_ret) m_ins = m_ins + 1;
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty: observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cur_st  = e.st;
            cur_ret = e.ret;
            chk("state", 32'(state), 32'(e.st));
            chk("retire", 32'(retire), 32'(e.ret));
            chk("pc", pc, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("imem_req", 32'(imem_req), 32'(e.ireq));
            chk("dmem_req", 32'(dmem_req), 32'(e.dreq));
            chk("halted", 32'(halted), 32'(e.st == S_HALT));
`ifdef PERF_CNT_EN
            chk("cycle_cnt", cycle_cnt, m_cyc);
            chk("instret_cnt", instret_cnt, m_ins);
`else
            chk("cycle_cnt", cycle_cnt, 32'd0);
            chk("instret_cnt", instret_cnt, 32'd0);
`endif
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_is_load = 1'b0; dec_is_store = 1'b0; dec_illegal = 1'b0;
        push(S_FETCH, 1'b0, RPC, 1'b1, 1'b0);
        tick();
        cur_pc = RPC;
        exp_load = 32'd0;
        chk("rst_instr", instr, NOP);
        chk("rst_load_result", load_result, 32'd0);
        rst_n = 1'b1;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. ok = 0 means WB is expected to trap.
    task automatic run(input logic [31:0] word, input int kind, input logic [31:0] nxt,
                       input int mem_wait, input logic [31:0] rdata, input bit ok);
        int n_dreq = 0;
        imem_ack = 1'b1; imem_rdata = word; pc_next = nxt;
        dec_is_load = (kind == 1); dec_is_store = (kind == 2);
        push(S_DECODE, 1'b0, cur_pc, 1'b0, 1'b0); tick(); n_dreq += int'(dmem_req);
        imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0;
        chk("instr", instr, word);
        push(S_RREAD, 1'b0, cur_pc, 1'b0, 1'b0); tick(); n_dreq += int'(dmem_req);
        push(S_EXEC, 1'b0, cur_pc, 1'b0, 1'b0); tick(); n_dreq += int'(dmem_req);
        if (kind != 0) begin
            push(S_MEM, 1'b0, cur_pc, 1'b0, 1'b1); tick(); n_dreq += int'(dmem_req);
            for (int c = 1; c <= mem_wait; c++) begin
                dmem_ack = (c == mem_wait);
                dmem_rdata = (c == mem_wait) ? rdata : 32'h5555_AAAA;
                imem_ack = 1'b1;
                if (c < mem_wait) begin
                    push(S_MEM, 1'b0, cur_pc, 1'b0, 1'b1); tick(); n_dreq += int'(dmem_req);
                end
            end
        end
        push(S_WB, ok, cur_pc, 1'b0, 1'b0); tick(); n_dreq += int'(dmem_req);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        if (kind == 1) exp_load = rdata;
        chk("load_result", load_result, exp_load);
        chk("instr_hold", instr, word);
        chk("dmem_req_cycles", n_dreq, (kind != 0) ? mem_wait : 0);
        if (ok) begin
            push(S_FETCH, 1'b0, nxt, 1'b1, 1'b0); tick();
            cur_pc = nxt;
        end else begin
            push(S_HALT, 1'b0, cur_pc, 1'b0, 1'b0); tick();
        end
        dec_is_load = 1'b0; dec_is_store = 1'b0;
    endtask

    initial begin
        logic [31:0] nxt;
        imem_rdata = 32'd0; dmem_rdata = 32'd0; pc_next = 32'd0;
        cur_pc = RPC; exp_load = 32'd0;
        do_reset();

        // Ten back-to-back ALU instructions, including a jump to the top word and a wrap to 0.
        for (int i = 0; i < 10; i++) begin
            nxt = (i == 3) ? 32'hFFFF_FFFC : (i == 4) ? 32'h0000_0000 : cur_pc + 32'd4;
            run(32'h0010_0093 + 32'(i), 0, nxt, 0, 32'd0, 1'b1);
        end
`ifdef PERF_CNT_EN
        chk("cycle_cnt_10", cycle_cnt, 32'd50);
        chk("instret_cnt_10", instret_cnt, 32'd10);
`else
        chk("cycle_cnt_10", cycle_cnt, 32'd0);
        chk("instret_cnt_10", instret_cnt, 32'd0);
`endif

        run(32'h0000_2083, 1, cur_pc + 32'd4, 3, 32'hDEAD_BEEF, 1'b1);
        run(32'h0010_2023, 2, cur_pc + 32'd4, 1, 32'h0BAD_0BAD, 1'b1);

        // Illegal instruction traps; HALT ignores stray acks until reset.
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; dec_illegal = 1'b1;
        push(S_DECODE, 1'b0, cur_pc, 1'b0, 1'b0); tick();
        imem_ack = 1'b0;
        push(S_HALT, 1'b0, cur_pc, 1'b0, 1'b0); tick();
        dec_illegal = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; pc_next = cur_pc + 32'd4;
        for (int i = 0; i < 20; i++) begin
            push(S_HALT, 1'b0, cur_pc, 1'b0, 1'b0); tick();
        end
        do_reset();

        run(32'h0000_0067, 0, 32'h0000_0102, 0, 32'd0, 1'b0);
        do_reset();

        run(32'h0000_2103, 1, cur_pc + 32'd4, 2, 32'hCAFE_F00D, 1'b1);

        // Reset while waiting in MEM with both acks high.
        imem_ack = 1'b1; imem_rdata = 32'h0000_2183; dec_is_load = 1'b1; pc_next = cur_pc + 32'd4;
        push(S_DECODE, 1'b0, cur_pc, 1'b0, 1'b0); tick();
        imem_ack = 1'b0;
        push(S_RREAD, 1'b0, cur_pc, 1'b0, 1'b0); tick();
        push(S_EXEC, 1'b0, cur_pc, 1'b0, 1'b0); tick();
        push(S_MEM, 1'b0, cur_pc, 1'b0, 1'b1); tick();
        rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        push(S_FETCH, 1'b0, RPC, 1'b1, 1'b0); tick();
        cur_pc = RPC; exp_load = 32'd0;
        chk("mem_rst_load_result", load_result, 32'd0);
        rst_n = 1'b1; imem_ack = 1'b0;
        push(S_FETCH, 1'b0, RPC, 1'b1, 1'b0); tick();
        chk("late_ack_load_result", load_result, 32'd0);
        dmem_ack = 1'b0; dec_is_load = 1'b0;

        run(32'h0030_0213, 0, cur_pc + 32'd4, 0, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on posedge clk.
REQ-004 SHALL have port state, output, 3, phase code driven to the register file and datapath.
REQ-005 SHALL have ports imem_req (output, 1), imem_addr (output, 32, equals pc), imem_ack (input, 1) and imem_rdata (input, 32): the instruction-fetch handshake.
REQ-006 SHALL have ports dmem_req (output, 1), dmem_ack (input, 1), dmem_rdata (input, 32) and load_result (output, 32, the latched load data).
REQ-007 SHALL have ports instr (output, 32, the latched instruction) and pc (output, 32, the current PC).
REQ-008 SHALL have decoder inputs dec_is_load, dec_is_store and dec_illegal (1 each) and input pc_next (32), the next PC from execute.
REQ-009 SHALL have outputs retire (1, one-cycle pulse per completed instruction) and halted (1).
REQ-010 SHALL have outputs cycle_cnt (32) and instret_cnt (32).

Function
REQ-011 SHALL encode state as FETCH=0, DECODE=1, RREAD=2, EXEC=3, WB=4, MEM=5 and HALT=6; code 7 is unreachable and SHALL go to HALT.
REQ-012 SHALL hold imem_req high for every cycle in FETCH and low otherwise.
REQ-013 In FETCH with imem_ack=1, SHALL latch imem_rdata into instr and go to DECODE next cycle; imem_ack outside FETCH SHALL be ignored.
REQ-014 In DECODE, SHALL go to HALT if dec_illegal=1, else to RREAD.
REQ-015 SHALL stay in RREAD exactly one cycle, then go to EXEC; the register file samples its operands in this phase.
REQ-016 In EXEC, SHALL go to MEM if dec_is_load or dec_is_store is 1, else to WB.
REQ-017 SHALL hold dmem_req high for every cycle in MEM; on dmem_ack=1, SHALL latch dmem_rdata into load_result (loads only) and go to WB.
REQ-018 In WB, SHALL pulse retire for one cycle, load pc with pc_next, and go to FETCH.
REQ-019 In WB with pc_next[1:0]!=0, SHALL not retire, SHALL keep pc unchanged and SHALL go to HALT.
REQ-020 pc_next=0 after pc=32'hFFFF_FFFC SHALL be accepted; there is no wrap check.
REQ-021 HALT SHALL be absorbing until reset; halted=1 only in HALT; no req is asserted in HALT.
REQ-022 Minimum latency SHALL be 5 cycles for non-memory instructions and 6 for memory instructions, with single-cycle acks.
REQ-023 A stalled ack SHALL hold the current state and all outputs stable indefinitely; there is no timeout.

Reset
REQ-024 When rst_n=0 at posedge, SHALL set state=FETCH, pc=RESET_PC, instr=32'h0000_0013, load_result=0, retire=0 and counters=0.
REQ-025 Reset SHALL take priority over every transition; reset in FETCH or MEM SHALL drop dmem_req the next cycle, and any late ack SHALL be ignored.
REQ-026 On the first cycle after reset release, SHALL be in FETCH with imem_req=1.

Configuration
REQ-027 With PERF_CNT_EN defined, cycle_cnt SHALL increment every non-HALT cycle outside reset, and instret_cnt SHALL increment on each retire; both wrap modulo 2^32.
REQ-028 Without PERF_CNT_EN, cycle_cnt and instret_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-029 The state encodings, the NOP constant and the RESET_PC default SHALL live in the shared package core_pkg, which the register file also uses.
REQ-030 The counters SHALL be one sub-module, seq_perf_cnt, instantiated only under PERF_CNT_EN.

Verification
REQ-031 ALU instruction, acks in the same cycle, pc_next=4: state sequence 0,1,2,3,4,0; retire pulses in cycle 5; pc=4.
REQ-032 Load, dmem_ack delayed 3 cycles, dmem_rdata=32'hDEADBEEF: MEM held 3 cycles; load_result=32'hDEADBEEF at WB; dmem_req high exactly 3 cycles.
REQ-033 dec_illegal=1 in DECODE: state=6; halted=1; imem_req stays 0 for 20 cycles; rst_n low restores pc=RESET_PC.
REQ-034 pc_next=32'h0000_0102 in WB: state goes to HALT; retire=0; pc unchanged.
REQ-035 rst_n pulsed low in MEM with imem_ack and dmem_ack both high: next state=FETCH, pc=RESET_PC, dmem_req=0, no retire.
REQ-036 PERF_CNT_EN defined, 10 ALU instructions: instret_cnt=10 and cycle_cnt=50; without the macro both read 0.
